// File: rtl/intr_arbiter.sv
// Interrupt arbiter: latches source events as pending, masks them, picks the lowest
// eligible index and offers it to the trap handler via req/ack, blocking until rfi.
module intr_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int VEC_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] intr_in,
  input  logic               hazard,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_data,
  input  logic [NUM_SRC-1:0] lost_clr,
  input  logic               intr_ack,
  input  logic               rfi,
  output logic               intr_req,
  output logic [VEC_W-1:0]   intr_vec,
  output logic               in_service,
  output logic [NUM_SRC-1:0] intr_pend,
  output logic [NUM_SRC-1:0] intr_mask,
  output logic [NUM_SRC-1:0] intr_lost
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SVC
  } state_t;

  state_t               state, state_nxt;
  logic                 req_nxt, svc_nxt;
  logic [VEC_W-1:0]     vec_nxt;
  logic [VEC_W-1:0]     winner;
  logic                 any_elig;
  logic                 ack_take;
  logic [NUM_SRC-1:0]   eligible, pend_clr, pend_nxt, lost_nxt;

  assign eligible = intr_pend & ~intr_mask;
  assign any_elig = |eligible;
  assign ack_take = (state == REQ) && intr_ack;

  // Scan from the top down so the lowest eligible index is the one left in winner.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = VEC_W'(i);
    end
  end

  always_comb begin
    pend_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pend_clr[i] = ack_take && (intr_vec == VEC_W'(i));
    end
  end

  // A new event always wins over a clear landing on the same bit.
  assign pend_nxt = (intr_pend & ~pend_clr) | intr_in;
  assign lost_nxt = (intr_lost & ~lost_clr) | (intr_in & intr_pend & ~pend_clr);

  // NOTE: every output of this block is given a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    req_nxt   = intr_req;
    vec_nxt   = intr_vec;
    svc_nxt   = in_service;
    unique case (state)
      IDLE: begin
        if (any_elig && !hazard) begin
          vec_nxt   = winner;
          req_nxt   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (intr_ack) begin
          req_nxt   = 1'b0;
          svc_nxt   = 1'b1;
          state_nxt = SVC;
        end
      end
      SVC: begin
        if (rfi) begin
          svc_nxt = 1'b0;
          // Issue straight from rfi so a waiting source is requested one cycle later.
          if (any_elig && !hazard) begin
            vec_nxt   = winner;
            req_nxt   = 1'b1;
            state_nxt = REQ;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // together from the values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      intr_req   <= 1'b0;
      intr_vec   <= '0;
      in_service <= 1'b0;
      intr_pend  <= '0;
      intr_mask  <= '0;
      intr_lost  <= '0;
    end else begin
      state      <= state_nxt;
      intr_req   <= req_nxt;
      intr_vec   <= vec_nxt;
      in_service <= svc_nxt;
      intr_pend  <= pend_nxt;
      intr_lost  <= lost_nxt;
      if (mask_we) intr_mask <= mask_data;
    end
  end

endmodule

// File: tb/tb_intr_arbiter.sv
// Self-checking bench for intr_arbiter: directed vector table, reset sequence, and
// randomized traffic checked against a behavioural model.
module tb_intr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] intr_in;
  logic       hazard;
  logic       mask_we;
  logic [2:0] mask_data;
  logic [2:0] lost_clr;
  logic       intr_ack;
  logic       rfi;
  logic       intr_req;
  logic [1:0] intr_vec;
  logic       in_service;
  logic [2:0] intr_pend;
  logic [2:0] intr_mask;
  logic [2:0] intr_lost;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  intr_arbiter #(.NUM_SRC(3), .VEC_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .intr_in    (intr_in),
    .hazard     (hazard),
    .mask_we    (mask_we),
    .mask_data  (mask_data),
    .lost_clr   (lost_clr),
    .intr_ack   (intr_ack),
    .rfi        (rfi),
    .intr_req   (intr_req),
    .intr_vec   (intr_vec),
    .in_service (in_service),
    .intr_pend  (intr_pend),
    .intr_mask  (intr_mask),
    .intr_lost  (intr_lost)
  );

  // ---------------- behavioural model ----------------
  // mode: 0 = idle, 1 = request outstanding, 2 = servicing
  int m_mode;
  int m_vec;
  bit m_req, m_svc;
  bit m_pend[3];
  bit m_mask[3];
  bit m_lost[3];

  task automatic model_step();
    bit np[3];
    bit nl[3];
    int cleared;
    int elig[$];
    if (rst) begin
      m_mode = 0; m_vec = 0; m_req = 0; m_svc = 0;
      for (int i = 0; i < 3; i++) begin
        m_pend[i] = 0; m_mask[i] = 0; m_lost[i] = 0;
      end
      return;
    end
    cleared = (m_mode == 1 && intr_ack) ? m_vec : -1;
    for (int i = 0; i < 3; i++) if (m_pend[i] && !m_mask[i]) elig.push_back(i);
    for (int i = 0; i < 3; i++) begin
      np[i] = intr_in[i] || (m_pend[i] && cleared != i);
      nl[i] = (intr_in[i] && m_pend[i] && cleared != i) || (m_lost[i] && !lost_clr[i]);
    end
    case (m_mode)
      0: if (elig.size() > 0 && !hazard) begin
           m_mode = 1; m_req = 1; m_vec = elig[0];
         end
      1: if (intr_ack) begin
           m_mode = 2; m_req = 0; m_svc = 1;
         end
      default: if (rfi) begin
           m_svc = 0;
           if (elig.size() > 0 && !hazard) begin
             m_mode = 1; m_req = 1; m_vec = elig[0];
           end else begin
             m_mode = 0;
           end
         end
    endcase
    for (int i = 0; i < 3; i++) begin
      if (mask_we) m_mask[i] = mask_data[i];
      m_pend[i] = np[i];
      m_lost[i] = nl[i];
    end
  endtask

  function automatic logic [12:0] model_obs();
    logic [2:0] p, k, l;
    for (int i = 0; i < 3; i++) begin
      p[i] = m_pend[i]; k[i] = m_mask[i]; l[i] = m_lost[i];
    end
    return {m_req, 2'(m_vec), m_svc, p, k, l};
  endfunction

  function automatic logic [12:0] dut_obs();
    return {intr_req, intr_vec, in_service, intr_pend, intr_mask, intr_lost};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got req/vec/svc/pend/mask/lost=%b, expected %b", name, got, exp);
  endtask

  task automatic idle_inputs();
    intr_in = '0; hazard = 0; mask_we = 0; mask_data = '0;
    lost_clr = '0; intr_ack = 0; rfi = 0;
  endtask

  // Advance one clock: model sees the same inputs as the DUT, outputs sampled 1 after the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] in;
    logic       hz;
    logic       mwe;
    logic [2:0] md;
    logic [2:0] lc;
    logic       ack;
    logic       rfi;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int in, input int hz, input int mwe, input int md, input int lc,
                     input int ack, input int rf, input int req, input int v, input int svc,
                     input int pend, input int mask, input int lost);
    vec_t r;
    r.in = 3'(in); r.hz = 1'(hz); r.mwe = 1'(mwe); r.md = 3'(md); r.lc = 3'(lc);
    r.ack = 1'(ack); r.rfi = 1'(rf);
    r.exp = {1'(req), 2'(v), 1'(svc), 3'(pend), 3'(mask), 3'(lost)};
    tbl.push_back(r);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    cycle();
    cycle();
    check("reset_state", dut_obs(), 13'b0);
    rst = 0;

    //   in   hz mwe md   lc   ack rfi | req vec svc pend  mask  lost
    // single event on source 1
    add('b010, 0, 0, 0,   0,    0, 0,    0, 0, 0, 'b010, 0,    0);
    add(0,     0, 0, 0,   0,    0, 0,    1, 1, 0, 'b010, 0,    0);
    add(0,     0, 0, 0,   0,    1, 0,    0, 1, 1, 0,     0,    0);
    add(0,     0, 0, 0,   0,    0, 1,    0, 1, 0, 0,     0,    0);
    // two sources: 1 before 2, 2 requested the cycle after rfi
    add('b110, 0, 0, 0,   0,    0, 0,    0, 1, 0, 'b110, 0,    0);
    add(0,     0, 0, 0,   0,    0, 0,    1, 1, 0, 'b110, 0,    0);
    add(0,     0, 0, 0,   0,    1, 0,    0, 1, 1, 'b100, 0,    0);
    add(0,     0, 0, 0,   0,    0, 1,    1, 2, 0, 'b100, 0,    0);
    add(0,     0, 0, 0,   0,    1, 0,    0, 2, 1, 0,     0,    0);
    add(0,     0, 0, 0,   0,    0, 1,    0, 2, 0, 0,     0,    0);
    // all three: order 0,1,2
    add('b111, 0, 0, 0,   0,    0, 0,    0, 2, 0, 'b111, 0,    0);
    add(0,     0, 0, 0,   0,    0, 0,    1, 0, 0, 'b111, 0,    0);
    add(0,     0, 0, 0,   0,    1, 0,    0, 0, 1, 'b110, 0,    0);
    add(0,     0, 0, 0,   0,    0, 1,    1, 1, 0, 'b110, 0,    0);
    add(0,     0, 0, 0,   0,    1, 0,    0, 1, 1, 'b100, 0,    0);
    add(0,     0, 0, 0,   0,    0, 1,    1, 2, 0, 'b100, 0,    0);
    add(0,     0, 0, 0,   0,    1, 0,    0, 2, 1, 0,     0,    0);
    add(0,     0, 0, 0,   0,    0, 1,    0, 2, 0, 0,     0,    0);
    // hazard holds off selection for five cycles
    add('b001, 1, 0, 0,   0,    0, 0,    0, 2, 0, 'b001, 0,    0);
    add(0,     1, 0, 0,   0,    0, 0,    0, 2, 0, 'b001, 0,    0);
    add(0,     1, 0, 0,   0,    0, 0,    0, 2, 0, 'b001, 0,    0);
    add(0,     1, 0, 0,   0,    0, 0,    0, 2, 0, 'b001, 0,    0);
    add(0,     1, 0, 0,   0,    0, 0,    0, 2, 0, 'b001, 0,    0);
    add(0,     0, 0, 0,   0,    0, 0,    1, 0, 0, 'b001, 0,    0);
    add(0,     0, 0, 0,   0,    1, 0,    0, 0, 1, 0,     0,    0);
    add(0,     0, 0, 0,   0,    0, 1,    0, 0, 0, 0,     0,    0);
    // masked source latches but is not selected until unmasked
    add('b001, 0, 1, 'b001, 0,  0, 0,    0, 0, 0, 'b001, 'b001, 0);
    add(0,     0, 0, 0,   0,    0, 0,    0, 0, 0, 'b001, 'b001, 0);
    add(0,     0, 1, 0,   0,    0, 0,    0, 0, 0, 'b001, 0,    0);
    add(0,     0, 0, 0,   0,    0, 0,    1, 0, 0, 'b001, 0,    0);
    add(0,     0, 0, 0,   0,    1, 0,    0, 0, 1, 0,     0,    0);
    add(0,     0, 0, 0,   0,    0, 1,    0, 0, 0, 0,     0,    0);
    // lost flag, lost_clr vs new loss, set-wins against ack clear
    add('b001, 1, 0, 0,   0,    0, 0,    0, 0, 0, 'b001, 0,    0);
    add('b001, 1, 0, 0,   0,    0, 0,    0, 0, 0, 'b001, 0,    'b001);
    add('b001, 1, 0, 0,   'b001, 0, 0,   0, 0, 0, 'b001, 0,    'b001);
    add(0,     1, 0, 0,   'b001, 0, 0,   0, 0, 0, 'b001, 0,    0);
    add(0,     0, 0, 0,   0,    0, 0,    1, 0, 0, 'b001, 0,    0);
    add('b001, 0, 0, 0,   0,    1, 0,    0, 0, 1, 'b001, 0,    0);
    add(0,     1, 0, 0,   0,    0, 1,    0, 0, 0, 'b001, 0,    0);
    // ack in idle ignored; rfi in REQ ignored; ack+rfi in REQ takes ack only
    add(0,     1, 0, 0,   0,    1, 0,    0, 0, 0, 'b001, 0,    0);
    add(0,     0, 0, 0,   0,    0, 0,    1, 0, 0, 'b001, 0,    0);
    add(0,     0, 0, 0,   0,    0, 1,    1, 0, 0, 'b001, 0,    0);
    add(0,     0, 0, 0,   0,    1, 1,    0, 0, 1, 0,     0,    0);
    add(0,     0, 0, 0,   0,    0, 1,    0, 0, 0, 0,     0,    0);
    // issued request is stable against mask writes, new events and hazard
    add('b100, 0, 0, 0,   0,    0, 0,    0, 0, 0, 'b100, 0,    0);
    add(0,     0, 0, 0,   0,    0, 0,    1, 2, 0, 'b100, 0,    0);
    add('b001, 0, 1, 'b111, 0,  0, 0,    1, 2, 0, 'b101, 'b111, 0);
    add(0,     1, 0, 0,   0,    0, 0,    1, 2, 0, 'b101, 'b111, 0);
    add(0,     0, 0, 0,   0,    1, 0,    0, 2, 1, 'b001, 'b111, 0);
    add(0,     0, 1, 0,   0,    0, 0,    0, 2, 1, 'b001, 0,    0);
    add(0,     0, 0, 0,   0,    0, 1,    1, 0, 0, 'b001, 0,    0);
    add(0,     0, 0, 0,   0,    1, 0,    0, 0, 1, 0,     0,    0);
    add('b011, 0, 0, 0,   0,    0, 0,    0, 0, 1, 'b011, 0,    0);

    foreach (tbl[i]) begin
      intr_in = tbl[i].in; hazard = tbl[i].hz; mask_we = tbl[i].mwe; mask_data = tbl[i].md;
      lost_clr = tbl[i].lc; intr_ack = tbl[i].ack; rfi = tbl[i].rfi;
      cycle();
      check($sformatf("vector_row%0d", i), dut_obs(), tbl[i].exp);
    end
    idle_inputs();

    // reset during service with two sources pending
    rst = 1;
    cycle();
    check("reset_in_svc", dut_obs(), 13'b0);
    rst = 0;
    intr_in = 3'b001;
    cycle();
    intr_in = 3'b000;
    cycle();
    check("idle_after_reset", dut_obs(), {1'b1, 2'd0, 1'b0, 3'b001, 3'b000, 3'b000});

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      intr_in   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      hazard    = ($urandom_range(0, 3) == 0);
      mask_we   = ($urandom_range(0, 9) == 0);
      mask_data = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom);
      lost_clr  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
      intr_ack  = ($urandom_range(0, 2) == 0);
      rfi       = ($urandom_range(0, 2) == 0);
      cycle();
      check($sformatf("random_cycle%0d", n), dut_obs(), model_obs());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
